uart_seq_controller: RTL and testbench

Parametrised N-stage sequencer for the UART transmit path. It launches NUM_STAGES sub-FSMs in order and steers the UART mux to each one while it runs. It waits for each stage's done, then holds a programmable inter-stage gap so the UART can drain. It adds a per-stage timeout, an abort input, error reporting and restart from the finished state.

---
 rtl/uart_seq_controller.sv | 178 +++++++++++++++++
 tb/tb_uart_seq_controller.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_seq_controller.sv
// Sequencer for the UART transmit path: launches NUM_STAGES sub-FSMs in order,
// steers the UART mux to the running stage and inserts a drain gap between stages.
module uart_seq_controller #(
  parameter int NUM_STAGES     = 2,
  parameter int SEL_W          = 3,
  parameter int CNT_W          = 16,
  parameter int GAP_CYCLES     = 8192,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic [NUM_STAGES-1:0] o_stage_begin,
  input  logic [NUM_STAGES-1:0] i_stage_done,
  output logic [SEL_W-1:0]      o_uartsel,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [SEL_W-1:0]      o_err_stage
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_GAP,
    S_FINISH,
    S_ERROR
  } state_t;

  localparam logic [SEL_W-1:0] LAST_STAGE = SEL_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               GAP_EN     = (GAP_CYCLES != 0);
  localparam bit               TO_EN      = (TIMEOUT_CYCLES != 0);

  // The counter must be able to reach GAP_CYCLES-1 and TIMEOUT_CYCLES-1.
  if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
    $error("uart_seq_controller: NUM_STAGES must be in 1..8");
  end
  if ((longint'(1) << SEL_W) < longint'(NUM_STAGES)) begin : g_bad_sel
    $error("uart_seq_controller: SEL_W too narrow for NUM_STAGES");
  end
  if (GAP_CYCLES < 0 || longint'(GAP_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_gap
    $error("uart_seq_controller: CNT_W too narrow for GAP_CYCLES");
  end
  if (TIMEOUT_CYCLES < 0 || longint'(TIMEOUT_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_to
    $error("uart_seq_controller: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  state_t           r_state;
  logic [SEL_W-1:0] r_stage;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_err_stage;

  state_t                w_state_nxt;
  logic [SEL_W-1:0]      w_stage_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [SEL_W-1:0]      w_err_stage_nxt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_done_sel;
  logic                  w_busy_nxt;
  logic [NUM_STAGES-1:0] w_begin_nxt;

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  always_comb begin
    w_done_sel = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (r_stage == SEL_W'(i)) w_done_sel = i_stage_done[i];
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_stage_nxt     = r_stage;
    w_cnt_nxt       = r_cnt;
    w_err_stage_nxt = r_err_stage;
    if (r_state == S_IDLE) begin
      if (i_start && !i_abort) begin
        w_state_nxt = S_LAUNCH;
        w_stage_nxt = '0;
        w_cnt_nxt   = '0;
      end
    end else if (i_abort) begin
      w_state_nxt = S_IDLE;
      w_stage_nxt = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_LAUNCH: begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end
        // stage_done outranks a timeout landing on the same cycle.
        S_WAIT: begin
          if (w_done_sel) begin
            w_cnt_nxt = '0;
            if (r_stage == LAST_STAGE) begin
              w_state_nxt = S_FINISH;
            end else if (!GAP_EN) begin
              w_state_nxt = S_LAUNCH;
              w_stage_nxt = r_stage + SEL_W'(1);
            end else begin
              w_state_nxt = S_GAP;
            end
          end else if (TO_EN && r_cnt == TO_LAST) begin
            w_state_nxt     = S_ERROR;
            w_err_stage_nxt = r_stage;
            w_cnt_nxt       = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            w_state_nxt = S_LAUNCH;
            w_stage_nxt = r_stage + SEL_W'(1);
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        S_FINISH, S_ERROR: begin
          if (i_start) begin
            w_state_nxt = S_LAUNCH;
            w_stage_nxt = '0;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_stage_nxt = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign w_busy_nxt = (w_state_nxt == S_LAUNCH) || (w_state_nxt == S_WAIT) ||
                      (w_state_nxt == S_GAP);

  always_comb begin
    w_begin_nxt = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_begin_nxt[i] = (w_state_nxt == S_LAUNCH) && (w_stage_nxt == SEL_W'(i));
    end
  end

  // Outputs are registered from the next-state decode so they stay glitch-free.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_stage       <= '0;
      r_cnt         <= '0;
      r_err_stage   <= '0;
      o_stage_begin <= '0;
      o_uartsel     <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_stage       <= w_stage_nxt;
      r_cnt         <= w_cnt_nxt;
      r_err_stage   <= w_err_stage_nxt;
      o_stage_begin <= w_begin_nxt;
      o_uartsel     <= w_busy_nxt ? w_stage_nxt : '0;
      o_busy        <= w_busy_nxt;
      o_done        <= (w_state_nxt == S_FINISH);
      o_error       <= (w_state_nxt == S_ERROR);
    end
  end

  assign o_err_stage = r_err_stage;

endmodule

// File: tb/tb_uart_seq_controller.sv
// Bench for uart_seq_controller: two configurations checked every cycle against a
// phase/elapsed-time model, plus directed literal checks at the key cycles.
module tb_uart_seq_controller;

  localparam int A_STAGES = 3;
  localparam int A_GAP    = 4;
  localparam int A_TO     = 10;
  localparam int B_STAGES = 1;
  localparam int B_GAP    = 0;
  localparam int B_TO     = 0;

  typedef enum logic [2:0] {PH_OFF, PH_PULSE, PH_RUN, PH_DRAIN, PH_DONE, PH_FAIL} phase_e;
  typedef struct packed {
    phase_e ph;
    int     stage;
    int     elapsed;
    int     errStage;
  } model_t;

  logic clk = 1'b0;
  logic rstN;
  logic startA, abortA, startB, abortB;
  logic [2:0] stageDoneA, beginA, uartselA, errStageA;
  logic busyA, doneOutA, errorA;
  logic [0:0] stageDoneB, beginB;
  logic [2:0] uartselB, errStageB;
  logic busyB, doneOutB, errorB;

  int checks = 0;
  int errors = 0;
  model_t mA, mB;

  always #5 clk = ~clk;

  uart_seq_controller #(
    .NUM_STAGES(A_STAGES), .SEL_W(3), .CNT_W(16),
    .GAP_CYCLES(A_GAP), .TIMEOUT_CYCLES(A_TO)
  ) dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_start(startA), .i_abort(abortA),
    .o_stage_begin(beginA), .i_stage_done(stageDoneA), .o_uartsel(uartselA),
    .o_busy(busyA), .o_done(doneOutA), .o_error(errorA), .o_err_stage(errStageA)
  );

  uart_seq_controller #(
    .NUM_STAGES(B_STAGES), .SEL_W(3), .CNT_W(16),
    .GAP_CYCLES(B_GAP), .TIMEOUT_CYCLES(B_TO)
  ) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_start(startB), .i_abort(abortB),
    .o_stage_begin(beginB), .i_stage_done(stageDoneB), .o_uartsel(uartselB),
    .o_busy(busyB), .o_done(doneOutB), .o_error(errorB), .o_err_stage(errStageB)
  );

  function automatic model_t modelReset();
    model_t m;
    m.ph = PH_OFF;
    m.stage = 0;
    m.elapsed = 0;
    m.errStage = 0;
    return m;
  endfunction

  // One clock of sequencer behaviour: elapsed counts cycles already spent in a phase.
  function automatic model_t modelStep(model_t m, int numStages, int gapCycles,
                                       int timeoutCycles, logic start, logic abort,
                                       logic [7:0] done);
    model_t n = m;
    if (m.ph == PH_OFF) begin
      if (start && !abort) begin
        n.ph = PH_PULSE;
        n.stage = 0;
      end
    end else if (abort) begin
      n.ph = PH_OFF;
      n.stage = 0;
      n.elapsed = 0;
    end else begin
      case (m.ph)
        PH_PULSE: begin
          n.ph = PH_RUN;
          n.elapsed = 1;
        end
        PH_RUN: begin
          if (done[m.stage]) begin
            if (m.stage == numStages - 1) begin
              n.ph = PH_DONE;
            end else if (gapCycles == 0) begin
              n.ph = PH_PULSE;
              n.stage = m.stage + 1;
            end else begin
              n.ph = PH_DRAIN;
              n.elapsed = 1;
            end
          end else if (timeoutCycles != 0 && m.elapsed >= timeoutCycles) begin
            n.ph = PH_FAIL;
            n.errStage = m.stage;
          end else begin
            n.elapsed = m.elapsed + 1;
          end
        end
        PH_DRAIN: begin
          if (m.elapsed >= gapCycles) begin
            n.ph = PH_PULSE;
            n.stage = m.stage + 1;
          end else begin
            n.elapsed = m.elapsed + 1;
          end
        end
        default: begin
          if (start) begin
            n.ph = PH_PULSE;
            n.stage = 0;
          end
        end
      endcase
    end
    return n;
  endfunction

  function automatic logic [31:0] expBegin(model_t m);
    return (m.ph == PH_PULSE) ? (32'd1 << m.stage) : 32'd0;
  endfunction

  function automatic logic [31:0] expBusy(model_t m);
    return (m.ph == PH_PULSE || m.ph == PH_RUN || m.ph == PH_DRAIN) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] expSel(model_t m);
    return (expBusy(m) != 0) ? 32'(m.stage) : 32'd0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic sA, input logic aA, input logic [2:0] dA,
                               input logic sB, input logic aB, input logic dB);
    startA = sA;
    abortA = aA;
    stageDoneA = dA;
    startB = sB;
    abortB = aB;
    stageDoneB = dB;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mA <= modelReset();
      mB <= modelReset();
    end else begin
      mA <= modelStep(mA, A_STAGES, A_GAP, A_TO, startA, abortA, {5'b0, stageDoneA});
      mB <= modelStep(mB, B_STAGES, B_GAP, B_TO, startB, abortB, {7'b0, stageDoneB});
    end
  end

  // Outputs are registered, so mid-low-phase sampling sees settled values.
  always @(negedge clk) begin
    model_t eA, eB;
    eA = rstN ? mA : modelReset();
    eB = rstN ? mB : modelReset();
    checkOutput("A.begin",    32'(beginA),    expBegin(eA));
    checkOutput("A.uartsel",  32'(uartselA),  expSel(eA));
    checkOutput("A.busy",     32'(busyA),     expBusy(eA));
    checkOutput("A.done",     32'(doneOutA),  32'(eA.ph == PH_DONE));
    checkOutput("A.error",    32'(errorA),    32'(eA.ph == PH_FAIL));
    checkOutput("A.errStage", 32'(errStageA), 32'(eA.errStage));
    checkOutput("B.begin",    32'(beginB),    expBegin(eB));
    checkOutput("B.uartsel",  32'(uartselB),  expSel(eB));
    checkOutput("B.busy",     32'(busyB),     expBusy(eB));
    checkOutput("B.done",     32'(doneOutB),  32'(eB.ph == PH_DONE));
    checkOutput("B.error",    32'(errorB),    32'(eB.ph == PH_FAIL));
    checkOutput("B.errStage", 32'(errStageB), 32'(eB.errStage));
  end

  initial begin
    rstN = 1'b0;
    applyStimulus(0, 0, 3'b000, 0, 0, 0);
    #1;
    checkOutput("rst.A.busy", 32'(busyA), 32'd0);
    checkOutput("rst.A.begin", 32'(beginA), 32'd0);
    checkOutput("rst.B.done", 32'(doneOutB), 32'd0);
    waitCycles(2);
    rstN = 1'b1;

    // Full three-stage run with a four-cycle gap.
    waitCycles(1);
    applyStimulus(1, 0, 3'b000, 0, 0, 0);
    waitCycles(1);
    checkOutput("run.launch0.begin", 32'(beginA), 32'b001);
    applyStimulus(0, 0, 3'b000, 0, 0, 0);
    waitCycles(3);
    applyStimulus(0, 0, 3'b001, 0, 0, 0);
    waitCycles(1);
    checkOutput("run.gap0.busy", 32'(busyA), 32'd1);
    checkOutput("run.gap0.uartsel", 32'(uartselA), 32'd0);
    applyStimulus(0, 0, 3'b000, 0, 0, 0);
    waitCycles(4);
    checkOutput("run.launch1.begin", 32'(beginA), 32'b010);
    checkOutput("run.launch1.uartsel", 32'(uartselA), 32'd1);
    waitCycles(2);
    applyStimulus(0, 0, 3'b010, 0, 0, 0);
    waitCycles(1);
    applyStimulus(0, 0, 3'b000, 0, 0, 0);
    waitCycles(5);
    applyStimulus(0, 0, 3'b100, 0, 0, 0);
    waitCycles(1);
    checkOutput("run.finish.done", 32'(doneOutA), 32'd1);
    checkOutput("run.finish.busy", 32'(busyA), 32'd0);

    // Restart, foreign done ignored, done beats timeout on the last WAIT cycle.
    applyStimulus(1, 0, 3'b000, 0, 0, 0);
    waitCycles(1);
    checkOutput("restart.begin", 32'(beginA), 32'b001);
    checkOutput("restart.done", 32'(doneOutA), 32'd0);
    applyStimulus(0, 0, 3'b000, 0, 0, 0);
    waitCycles(1);
    applyStimulus(0, 0, 3'b010, 0, 0, 0);
    waitCycles(2);
    checkOutput("foreign.busy", 32'(busyA), 32'd1);
    checkOutput("foreign.uartsel", 32'(uartselA), 32'd0);
    applyStimulus(0, 0, 3'b000, 0, 0, 0);
    waitCycles(7);
    applyStimulus(0, 0, 3'b001, 0, 0, 0);
    waitCycles(1);
    checkOutput("tie.error", 32'(errorA), 32'd0);
    checkOutput("tie.busy", 32'(busyA), 32'd1);
    applyStimulus(0, 0, 3'b000, 0, 0, 0);

    // Stage 1 never completes: WAIT starts 5 cycles later, ERROR 10 cycles after that.
    waitCycles(14);
    checkOutput("timeout.pre.error", 32'(errorA), 32'd0);
    waitCycles(1);
    checkOutput("timeout.error", 32'(errorA), 32'd1);
    checkOutput("timeout.errStage", 32'(errStageA), 32'd1);
    checkOutput("timeout.busy", 32'(busyA), 32'd0);
    applyStimulus(1, 0, 3'b000, 0, 0, 0);
    waitCycles(1);
    checkOutput("errRestart.begin", 32'(beginA), 32'b001);
    checkOutput("errRestart.error", 32'(errorA), 32'd0);
    checkOutput("errRestart.errStage", 32'(errStageA), 32'd1);
    applyStimulus(0, 0, 3'b000, 0, 0, 0);

    // Abort during the gap, then abort+start together in IDLE.
    waitCycles(1);
    applyStimulus(0, 0, 3'b001, 0, 0, 0);
    waitCycles(1);
    checkOutput("abort.gap.busy", 32'(busyA), 32'd1);
    applyStimulus(0, 1, 3'b000, 0, 0, 0);
    waitCycles(1);
    checkOutput("abort.idle.busy", 32'(busyA), 32'd0);
    applyStimulus(1, 1, 3'b000, 0, 0, 0);
    waitCycles(2);
    checkOutput("abortStart.busy", 32'(busyA), 32'd0);
    checkOutput("abortStart.begin", 32'(beginA), 32'd0);
    applyStimulus(0, 0, 3'b000, 0, 0, 0);
    waitCycles(2);

    // Single stage, no gap, start held through FINISH.
    applyStimulus(0, 0, 3'b000, 1, 0, 0);
    waitCycles(1);
    checkOutput("B.launch.begin", 32'(beginB), 32'd1);
    waitCycles(1);
    applyStimulus(0, 0, 3'b000, 1, 0, 1);
    waitCycles(1);
    checkOutput("B.finish.done", 32'(doneOutB), 32'd1);
    checkOutput("B.finish.begin", 32'(beginB), 32'd0);
    applyStimulus(0, 0, 3'b000, 1, 0, 0);
    waitCycles(1);
    checkOutput("B.relaunch.begin", 32'(beginB), 32'd1);
    checkOutput("B.relaunch.done", 32'(doneOutB), 32'd0);
    applyStimulus(0, 0, 3'b000, 0, 0, 0);
    waitCycles(1);
    checkOutput("B.wait.busy", 32'(busyB), 32'd1);

    // Asynchronous reset in WAIT, away from any clock edge.
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("asyncRst.B.busy", 32'(busyB), 32'd0);
    checkOutput("asyncRst.B.begin", 32'(beginB), 32'd0);
    checkOutput("asyncRst.A.errStage", 32'(errStageA), 32'd0);
    waitCycles(2);
    rstN = 1'b1;
    waitCycles(3);
    checkOutput("release.B.busy", 32'(busyB), 32'd0);
    checkOutput("release.B.begin", 32'(beginB), 32'd0);
    checkOutput("release.A.begin", 32'(beginA), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
